// File: rtl/csr_regfile_rv32.sv
// Machine-mode Zicsr CSR file: scratch bank plus 64-bit mcycle/minstret with RO user aliases.
// Optional mcountinhibit (0x320) is built when CSR_COUNT_INHIBIT_EN is defined.
module csr_regfile_rv32 #(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 8,
  parameter logic [11:0] SCRATCH_BASE = 12'h7C0,
  parameter int          CNT_W        = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            instret_inc,
  output logic            csr_rvalid,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal
);

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("csr_regfile_rv32: only XLEN=32 is supported");
    end
    if (NUM_SCRATCH < 1 || NUM_SCRATCH > 64) begin : g_bad_nscr
      $error("csr_regfile_rv32: NUM_SCRATCH must be 1..64");
    end
    if (CNT_W < 33 || CNT_W > 64) begin : g_bad_cntw
      $error("csr_regfile_rv32: CNT_W must be 33..64");
    end
  endgenerate

  localparam int SW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MCNTINH   = 12'h320;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] data;
    logic            ill;
  } rsp_t;

  logic [NUM_SCRATCH-1:0][XLEN-1:0] scratch;
  logic [CNT_W-1:0] mcycle, minstret;
  logic [63:0]      cyc64, ins64, cyc_wr, ins_wr;
  logic             inh_cy, inh_ir;

  logic [12:0]      soff;
  logic [SW-1:0]    sidx;
  logic             in_scr, hit, wr_intent, acc_illegal, we;
  logic [XLEN-1:0]  old_val, new_val;
  rsp_t             rsp_q;

  assign cyc64 = 64'(mcycle);
  assign ins64 = 64'(minstret);

  // Offset in 13 bits so addresses below the base wrap far out of range.
  assign soff   = {1'b0, csr_addr} - {1'b0, SCRATCH_BASE};
  assign in_scr = soff < 13'(NUM_SCRATCH);
  assign sidx   = soff[SW-1:0];

  always_comb begin
    hit     = 1'b0;
    old_val = '0;
    if (in_scr) begin
      hit     = 1'b1;
      old_val = scratch[sidx];
    end else begin
      case (csr_addr)
        A_MCYCLE,   A_CYCLE:    begin hit = 1'b1; old_val = cyc64[31:0];  end
        A_MCYCLEH,  A_CYCLEH:   begin hit = 1'b1; old_val = cyc64[63:32]; end
        A_MINSTRET, A_INSTRET:  begin hit = 1'b1; old_val = ins64[31:0];  end
        A_MINSTRETH,A_INSTRETH: begin hit = 1'b1; old_val = ins64[63:32]; end
`ifdef CSR_COUNT_INHIBIT_EN
        A_MCNTINH: begin hit = 1'b1; old_val = {29'b0, inh_ir, 1'b0, inh_cy}; end
`endif
        default: ;
      endcase
    end
  end

  // RS/RC with a zero operand are pure reads, so they stay legal on RO space.
  assign wr_intent   = (csr_op == OP_RW) || ((csr_op != 2'b00) && (|csr_wdata));
  assign acc_illegal = (csr_op == 2'b00) || !hit ||
                       (wr_intent && (csr_addr[11:10] == 2'b11));
  assign we          = csr_valid && !acc_illegal && wr_intent;

  always_comb begin
    case (csr_op)
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = csr_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (we && in_scr) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (sidx == SW'(i)) scratch[i] <= new_val;
    end
  end

  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  assign wr_cyc_lo = we && (csr_addr == A_MCYCLE);
  assign wr_cyc_hi = we && (csr_addr == A_MCYCLEH);
  assign wr_ins_lo = we && (csr_addr == A_MINSTRET);
  assign wr_ins_hi = we && (csr_addr == A_MINSTRETH);

  // Half-writes merge into the zero-extended view; bits above CNT_W fall off.
  always_comb begin
    cyc_wr = cyc64;
    ins_wr = ins64;
    if (wr_cyc_lo) cyc_wr[31:0]  = new_val;
    if (wr_cyc_hi) cyc_wr[63:32] = new_val;
    if (wr_ins_lo) ins_wr[31:0]  = new_val;
    if (wr_ins_hi) ins_wr[63:32] = new_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_cyc_lo || wr_cyc_hi) mcycle <= cyc_wr[CNT_W-1:0];
      else if (!inh_cy)           mcycle <= mcycle + CNT_W'(1);
      if (wr_ins_lo || wr_ins_hi)      minstret <= ins_wr[CNT_W-1:0];
      else if (instret_inc && !inh_ir) minstret <= minstret + CNT_W'(1);
    end
  end

`ifdef CSR_COUNT_INHIBIT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inh_cy <= 1'b0;
      inh_ir <= 1'b0;
    end else if (we && (csr_addr == A_MCNTINH)) begin
      inh_cy <= new_val[0];
      inh_ir <= new_val[2];
    end
  end
`else
  assign inh_cy = 1'b0;
  assign inh_ir = 1'b0;
`endif

  // Data/flag hold when idle; only the valid bit tracks every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.vld <= csr_valid;
      if (csr_valid) begin
        rsp_q.data <= acc_illegal ? '0 : old_val;
        rsp_q.ill  <= acc_illegal;
      end
    end
  end

  assign csr_rvalid  = rsp_q.vld;
  assign csr_rdata   = rsp_q.data;
  assign csr_illegal = rsp_q.ill;

endmodule
